// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, BITS_PER_CYCLE multiplier bits retired per clock, start/done handshake.
// Define MULT_SIGNED_EN to honour is_signed (magnitude multiply plus final negate); otherwise unsigned only.
module mult_seq #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned CYCLES = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW     = $clog2(CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_z;
  logic            r_busy;
  logic            r_done;

  logic            w_load;
  logic            w_step;
  logic            w_last;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [PW-1:0]   w_partial;
  logic [PW-1:0]   w_acc_nxt;
  logic [PW-1:0]   w_prod;

  assign w_last = (r_cnt == CW'(CYCLES - 1));

  // Operand conditioning and result sign fix-up
`ifdef MULT_SIGNED_EN
  logic r_neg;
  logic w_neg_in;
  assign w_neg_in = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign w_mag_a  = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b  = (is_signed && b[WIDTH-1]) ? -b : b;
  assign w_prod   = r_neg ? -w_acc_nxt : w_acc_nxt;

  always_ff @(posedge clk) begin
    if (!reset)      r_neg <= 1'b0;
    else if (w_load) r_neg <= w_neg_in;
  end
`else
  logic w_unused_is_signed;
  assign w_unused_is_signed = is_signed;
  assign w_mag_a = a;
  assign w_mag_b = b;
  assign w_prod  = w_acc_nxt;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath controls decoded from state
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      S_IDLE:  w_load = start;
      S_RUN:   w_step = 1'b1;
      S_DONE:  w_load = start;
      default: w_load = 1'b0;
    endcase
  end

  // Sum of shifted multiplicand copies for the low multiplier bits
  always_comb begin
    w_partial = '0;
    for (int k = 0; k < int'(BITS_PER_CYCLE); k++) begin
      if (r_mplier[k]) w_partial = w_partial + (r_mcand << k);
    end
    w_acc_nxt = r_acc + w_partial;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_z      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_next == S_RUN);
      r_done <= (w_next == S_DONE);
      if (w_load) begin
        r_cnt    <= '0;
        r_mcand  <= PW'(w_mag_a);
        r_mplier <= w_mag_b;
        r_acc    <= '0;
      end else if (w_step) begin
        r_cnt    <= r_cnt + CW'(1);
        r_mcand  <= r_mcand << BITS_PER_CYCLE;
        r_mplier <= r_mplier >> BITS_PER_CYCLE;
        r_acc    <= w_acc_nxt;
        if (w_last) r_z <= w_prod;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign z    = r_z;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: one 1-bit/cycle and one 4-bit/cycle instance, 32-bit operands.
// Expected products are hand-computed; signed expectations follow MULT_SIGNED_EN.
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start4;
  logic        is_signed;
  logic [31:0] a, b;
  logic        busy1, done1, busy4, done4;
  logic [63:0] z1, z4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy1), .done(done1), .z(z1)
  );

  mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy4), .done(done4), .z(z4)
  );

`ifdef MULT_SIGNED_EN
  localparam logic [63:0] EXP_N3X7   = 64'hFFFF_FFFF_FFFF_FFEB;
  localparam logic [63:0] EXP_N1X1   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] EXP_N1XN1  = 64'h0000_0000_0000_0001;
`else
  localparam logic [63:0] EXP_N3X7   = 64'h0000_0006_FFFF_FFEB;
  localparam logic [63:0] EXP_N1X1   = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] EXP_N1XN1  = 64'hFFFF_FFFE_0000_0001;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation on the 1-bit instance: done must rise 32 edges after the accepting edge
  task automatic run1(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                      input logic sgn, input logic [63:0] exp);
    int n;
    a = op_a; b = op_b; is_signed = sgn; start1 = 1'b1;
    tick();
    start1 = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
    check({tag, "_busy"}, 64'(busy1), 64'd1);
    n = 0;
    while (!done1 && n < 40) begin tick(); n++; end
    check({tag, "_lat"}, 64'(n), 64'd32);
    check({tag, "_z"}, z1, exp);
    check({tag, "_busy_at_done"}, 64'(busy1), 64'd0);
    tick();
    check({tag, "_done_pulse"}, 64'(done1), 64'd0);
    check({tag, "_z_hold"}, z1, exp);
  endtask

  logic [31:0] tab_a [8];
  logic [31:0] tab_b [8];
  logic [63:0] tab_z [8];

  initial begin
    int n, n_done, first_done;

    tab_a = '{32'd1, 32'd2, 32'hFFFF_FFFF, 32'h0001_0000, 32'd0, 32'h8000_0000, 32'h0000_FFFF, 32'd100};
    tab_b = '{32'd1, 32'd3, 32'hFFFF_FFFF, 32'h0001_0000, 32'h1234, 32'd2, 32'h0000_FFFF, 32'd1000};
    tab_z = '{64'd1, 64'd6, 64'hFFFF_FFFE_0000_0001, 64'h1_0000_0000, 64'd0,
              64'h1_0000_0000, 64'h0000_0000_FFFE_0001, 64'd100000};

    // Reset held two cycles with start asserted
    reset = 1'b0; start1 = 1'b1; start4 = 1'b1; is_signed = 1'b0; a = 32'd5; b = 32'd5;
    tick();
    check("rst1_busy", 64'(busy1), 64'd0);
    check("rst1_done", 64'(done1), 64'd0);
    check("rst1_z", z1, 64'd0);
    tick();
    check("rst2_busy", 64'(busy1), 64'd0);
    check("rst2_done", 64'(done1), 64'd0);
    check("rst2_z", z1, 64'd0);
    check("rst2_busy4", 64'(busy4), 64'd0);
    reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
    tick();
    check("post_rst_busy", 64'(busy1), 64'd0);

    // Unsigned boundary and plain products
    run1("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run1("u_zero", 32'd0, 32'hFFFF_FFFF, 1'b0, 64'd0);
    run1("u_pow", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h1_0000_0000);
    run1("u_m1x1", 32'hFFFF_FFFF, 32'd1, 1'b0, 64'h0000_0000_FFFF_FFFF);

    // Signed mode (unsigned results when the feature is not built)
    run1("s_n3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, EXP_N3X7);
    run1("s_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    run1("s_n1x1", 32'hFFFF_FFFF, 32'd1, 1'b1, EXP_N1X1);
    run1("s_n1xn1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, EXP_N1XN1);
    run1("s_pos", 32'd6, 32'd7, 1'b1, 64'd42);

    // start pulsed mid-RUN is ignored
    a = 32'd3; b = 32'd5; is_signed = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n_done = 0; first_done = -1;
    for (int i = 1; i <= 45; i++) begin
      if (i == 5) begin a = 32'd7; b = 32'd9; start1 = 1'b1; end
      if (i == 6) start1 = 1'b0;
      tick();
      if (done1) begin
        n_done++;
        if (first_done < 0) first_done = i;
      end
    end
    check("ign_done_cnt", 64'(n_done), 64'd1);
    check("ign_lat", 64'(first_done), 64'd32);
    check("ign_z", z1, 64'd15);

    // Reset in the middle of RUN aborts without a done pulse
    a = 32'd6; b = 32'd7; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("abort_busy_pre", 64'(busy1), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_z", z1, 64'd0);
    check("abort_busy", 64'(busy1), 64'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done1) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    run1("after_abort", 32'd6, 32'd7, 1'b0, 64'd42);

    // Back-to-back on the 4-bit instance: restart during each done cycle
    is_signed = 1'b0; a = tab_a[0]; b = tab_b[0]; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin tick(); n++; end
    check("b2b0_lat", 64'(n), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b%0d_z", i), z4, tab_z[i]);
      check($sformatf("b2b%0d_busy", i), 64'(busy4), 64'd0);
      if (i < 7) begin
        a = tab_a[i+1]; b = tab_b[i+1]; start4 = 1'b1;
        tick();
        start4 = 1'b0; a = $urandom; b = $urandom;
        check($sformatf("b2b%0d_pulse", i), 64'(done4), 64'd0);
        n = 1;
        while (!done4 && n < 20) begin tick(); n++; end
        check($sformatf("b2b%0d_period", i + 1), 64'(n), 64'd9);
      end
    end
    tick();
    check("b2b_idle_done", 64'(done4), 64'd0);
    check("b2b_idle_z", z4, tab_z[7]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
